// File: rtl/sender_fsm_if.sv
// Handshake bundle for sender_fsm: upstream valid/ready word input plus the
// req/ack/data lines that cross into the receiving clock domain.
interface sender_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  send_valid;
  logic [DATA_WIDTH-1:0] send_data;
  logic                  send_ready;
  logic                  req_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack_in;
  logic                  done;
  logic                  proto_err;

  // master is the transmit controller itself; slave is its environment
  modport master (
    input  send_valid, send_data, ack_in,
    output send_ready, req_out, data_out, done, proto_err
  );

  modport slave (
    output send_valid, send_data, ack_in,
    input  send_ready, req_out, data_out, done, proto_err
  );
endinterface

// File: rtl/sender_fsm.sv
// Transmit side of a four-phase req/ack CDC handshake: accepts one word,
// holds it on data_out, raises req_out and waits for the synchronized ack.
module sender_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  sender_fsm_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_prev_q, ack_prev_d;
  logic                   req_q, req_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ack_sync;
  logic                   send_ready;
  logic                   accept;

  // A high ack_sync in idle is a stale or spurious ack and must block acceptance
  assign ack_sync   = sync_q[SYNC_STAGES-1];
  assign send_ready = (state_q == S_IDLE) && !ack_sync;
  assign accept     = send_ready && bus.send_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      ack_prev_q <= 1'b0;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      ack_prev_q <= ack_prev_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_REQ;
      S_REQ:   if (ack_sync)  state_d = S_REL;
      S_REL:   if (!ack_sync) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // req_out is registered from the next state so it moves on the same edge as the FSM
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.ack_in};
    ack_prev_d = ack_sync;
    req_d      = (state_d == S_REQ);
    data_d     = accept ? bus.send_data : data_q;
    done_d     = (state_q == S_REL) && !ack_sync;
    err_d      = err_q | ((state_q == S_IDLE) && ack_sync && !ack_prev_q);
  end

  assign bus.send_ready = send_ready;
  assign bus.req_out    = req_q;
  assign bus.data_out   = data_q;
  assign bus.done       = done_q;
  assign bus.proto_err  = err_q;

endmodule
